registers_dump_unit: RTL and testbench
======================================

Name: registers_dump_unit

Overview:
- Downstream consumer of the ID-stage registers bank debug bus (flattened bank contents, register 0 in the least-significant slice).
- On a start request, snapshots the whole bank and streams it out one byte at a time over a valid/ready handshake toward the debug/UART transmit path.
- Lets the host read the full architectural register state without stalling or disturbing the pipeline.

Parameters:
- REGISTERS_BANK_SIZE, 32, number of registers in the bank.
- REGISTERS_SIZE, 32, bits per register; must be a multiple of 8.

Ports:
- i_clk  in  1  clock, all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  dump request, sampled only in IDLE.
- i_bus_debug  in  REGISTERS_BANK_SIZE*REGISTERS_SIZE  flattened bank contents; register k is at bits [k*REGISTERS_SIZE +: REGISTERS_SIZE].
- i_ready  in  1  consumer can accept a byte this cycle.
- o_data  out  8  current byte.
- o_valid  out  1  o_data is valid.
- o_busy  out  1  dump in progress (SEND or DONE).
- o_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Constants:
  - BYTES_PER_REG = REGISTERS_SIZE/8.
  - TOTAL_BYTES = REGISTERS_BANK_SIZE*BYTES_PER_REG.
  - Counters: reg_idx is $clog2(REGISTERS_BANK_SIZE) wide; byte_idx is $clog2(BYTES_PER_REG) wide, minimum 1 bit.
- Reset (i_reset=1 at an edge), takes priority over everything:
  - state=IDLE, snapshot=0, reg_idx=0, byte_idx=0.
  - o_valid=0, o_busy=0, o_done=0, o_data=0.
  - Reset mid-dump aborts the dump immediately with no o_done pulse.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - o_valid=0, o_busy=0, o_data=0.
  - Edge with i_start=1: snapshot <= i_bus_debug, reg_idx=0, byte_idx=0, next state SEND.
  - Latency is 1 cycle: o_valid rises the cycle after i_start is sampled.
- SEND:
  - o_valid=1, o_busy=1.
  - o_data = snapshot byte [reg_idx*REGISTERS_SIZE + byte_idx*8 +: 8].
  - Byte order: register 0 first; within each register, LSB byte first.
  - Transfer occurs on an edge with o_valid=1 and i_ready=1.
  - On transfer with byte_idx<BYTES_PER_REG-1: byte_idx++.
  - On transfer with the last byte of a register: byte_idx=0, reg_idx++.
  - On transfer of the last byte of the last register: next state DONE.
  - With i_ready=0: hold o_valid, o_data and counters unchanged. o_valid never drops without a transfer, except on reset.
  - i_ready held high streams one byte per cycle.
- DONE: o_done=1, o_busy=1, o_valid=0 for exactly one cycle; then IDLE.
- i_start is ignored in SEND and DONE; no queuing.
- i_start held high continuously restarts a fresh dump one cycle after DONE, re-snapshotting the bus.
- Changes on i_bus_debug after the snapshot edge never affect the streamed data.
- i_ready in IDLE/DONE has no effect.
- o_valid, o_busy and o_done are decoded from state; o_data is a combinational mux of registered state only, with no input-to-output path.

Test Plan:
- Reset then idle (BANK=4, SIZE=32): i_reset=1 for 3 cycles, then 0 with i_start=0 for 10 cycles -> o_valid=0, o_busy=0, o_done=0, o_data=0 throughout.
- Full dump, i_ready=1: regs = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; pulse i_start -> 16 consecutive bytes 0x00..0x0F starting 1 cycle after start; o_done pulses 1 cycle after the 16th transfer; o_busy low the following cycle.
- Backpressure: same data, i_ready random 0/1 (seeded) -> byte sequence still 0x00..0x0F in order; o_data and o_valid stable on every i_ready=0 cycle; no byte duplicated or skipped.
- Snapshot isolation: start dump with the above data, overwrite i_bus_debug with all 0xFF after 2 transfers -> remaining bytes still 0x02..0x0F.
- Start ignored while busy: assert i_start again at byte 5 -> no restart; exactly 16 bytes and one o_done pulse.
- Reset mid-dump: assert i_reset after byte 7 is accepted -> o_valid=0 next cycle, no o_done. A new i_start then begins again from byte 0x00.

Source files
------------

// File: rtl/registers_dump_unit.sv
// Register bank dump unit: on a start request it snapshots the flattened
// register bank debug bus and streams it out byte by byte over valid/ready.
// The order is register 0 first, and the LSB byte first within each register.
module registers_dump_unit #(
    parameter int unsigned REGISTERS_BANK_SIZE = 32,
    parameter int unsigned REGISTERS_SIZE      = 32
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic                                        i_start,
    input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
    input  logic                                        i_ready,
    output logic [7:0]                                  o_data,
    output logic                                        o_valid,
    output logic                                        o_busy,
    output logic                                        o_done
);

    localparam int unsigned BYTES_PER_REG = REGISTERS_SIZE / 8;
    localparam int unsigned TOTAL_BITS    = REGISTERS_BANK_SIZE * REGISTERS_SIZE;
    localparam int unsigned RW   = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;
    localparam int unsigned BW   = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
    localparam int unsigned OFFW = $clog2(TOTAL_BITS);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_t;

    state_t                  state_q;
    logic [TOTAL_BITS-1:0]   snapshot_q;
    logic [RW-1:0]           reg_idx_q;
    logic [BW-1:0]           byte_idx_q;
    logic                    last_byte;
    logic                    last_reg;
    logic [OFFW-1:0]         bit_off;

    assign last_byte = (byte_idx_q == BW'(BYTES_PER_REG - 1));
    assign last_reg  = (reg_idx_q == RW'(REGISTERS_BANK_SIZE - 1));

    // Dump sequencer: snapshot on start, advance the byte/register counters on each transfer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            snapshot_q <= '0;
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        snapshot_q <= i_bus_debug;
                        reg_idx_q  <= '0;
                        byte_idx_q <= '0;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (i_ready) begin
                        if (last_byte) begin
                            byte_idx_q <= '0;
                            if (last_reg) begin
                                reg_idx_q <= '0;
                                state_q   <= StDone;
                            end else begin
                                reg_idx_q <= reg_idx_q + RW'(1);
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + BW'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Bit offset of the current byte inside the snapshot.
    always_comb begin
        bit_off = (OFFW'(reg_idx_q) * OFFW'(REGISTERS_SIZE)) + (OFFW'(byte_idx_q) << 3);
    end

    // Output byte comes only from registered state; it reads as zero outside SEND.
    always_comb begin
        o_data = '0;
        if (state_q == StSend) begin
            o_data = snapshot_q[bit_off +: 8];
        end
    end

    assign o_valid = (state_q == StSend);
    assign o_busy  = (state_q == StSend) || (state_q == StDone);
    assign o_done  = (state_q == StDone);

endmodule

// File: tb/tb_registers_dump_unit.sv
// Self-checking bench for registers_dump_unit with a 4 x 32-bit bank.
module tb_registers_dump_unit;

    localparam int unsigned BANK = 4;
    localparam int unsigned SIZE = 32;
    localparam int unsigned NB   = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic                   ready = 1'b0;
    logic [BANK*SIZE-1:0]   bus;
    logic [7:0]             data;
    logic                   valid;
    logic                   busy;
    logic                   done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       start;
        logic       ready;
        logic       valid;
        logic [7:0] data;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[18];

    always #5 clk = ~clk;

    registers_dump_unit #(
        .REGISTERS_BANK_SIZE(BANK),
        .REGISTERS_SIZE(SIZE)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_start(start),
        .i_bus_debug(bus),
        .i_ready(ready),
        .o_data(data),
        .o_valid(valid),
        .o_busy(busy),
        .o_done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, take one rising edge, land 1 time unit after it.
    task automatic cyc(input logic s, input logic r);
        start = s;
        ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".valid"}, {31'd0, valid}, 32'd0);
        chk({name, ".busy"},  {31'd0, busy},  32'd0);
        chk({name, ".done"},  {31'd0, done},  32'd0);
        chk({name, ".data"},  {24'd0, data},  32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    logic [BANK*SIZE-1:0] pattern;

    initial begin
        pattern = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
        bus = pattern;

        // Full-dump table: entry k is the output seen after the k-th edge from start.
        for (int k = 0; k < 16; k++) begin
            vecs[k] = '{start: (k == 0), ready: 1'b1, valid: 1'b1, data: 8'(k),
                        busy: 1'b1, done: 1'b0};
        end
        vecs[16] = '{start: 1'b0, ready: 1'b1, valid: 1'b0, data: 8'h00, busy: 1'b1, done: 1'b1};
        vecs[17] = '{start: 1'b0, ready: 1'b1, valid: 1'b0, data: 8'h00, busy: 1'b0, done: 1'b0};

        // Reset then idle
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);
        chk_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            chk_idle("idle");
        end

        // Full dump with ready held high
        for (int k = 0; k < 18; k++) begin
            cyc(vecs[k].start, vecs[k].ready);
            chk($sformatf("full[%0d].valid", k), {31'd0, valid}, {31'd0, vecs[k].valid});
            chk($sformatf("full[%0d].data", k),  {24'd0, data},  {24'd0, vecs[k].data});
            chk($sformatf("full[%0d].busy", k),  {31'd0, busy},  {31'd0, vecs[k].busy});
            chk($sformatf("full[%0d].done", k),  {31'd0, done},  {31'd0, vecs[k].done});
        end

        // Backpressure with seeded random ready
        begin
            int          exp_idx;
            logic        r;
            logic [7:0]  prev_data;
            logic        prev_valid;
            bit          finished;
            void'($urandom(32'd1234));
            exp_idx  = 0;
            finished = 1'b0;
            cyc(1'b1, 1'b0);
            chk("bp.first", {23'd0, valid, data}, {23'd0, 1'b1, 8'h00});
            for (int c = 0; c < 200 && !finished; c++) begin
                prev_data  = data;
                prev_valid = valid;
                r = 1'($urandom_range(0, 1));
                cyc(1'b0, r);
                if (prev_valid && r) exp_idx++;
                if (exp_idx < 16) begin
                    chk("bp.byte", {23'd0, valid, data}, {23'd0, 1'b1, 8'(exp_idx)});
                    if (!r) chk("bp.hold", {23'd0, valid, data}, {23'd0, prev_valid, prev_data});
                end else begin
                    chk("bp.done", {31'd0, done}, 32'd1);
                    finished = 1'b1;
                end
            end
            if (!finished) chk("bp.timeout", 32'd0, 32'd1);
            cyc(1'b0, 1'b0);
            chk_idle("bp.after");
        end

        // Snapshot isolation
        bus = pattern;
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        bus = '1;
        for (int k = 2; k < 16; k++) begin
            chk("snap.byte", {23'd0, valid, data}, {23'd0, 1'b1, 8'(k)});
            cyc(1'b0, 1'b1);
        end
        chk("snap.done", {31'd0, done}, 32'd1);
        cyc(1'b0, 1'b0);
        bus = pattern;

        // Start ignored while busy
        begin
            int xfers;
            int dones;
            logic s;
            xfers = 0;
            dones = 0;
            cyc(1'b1, 1'b1);
            for (int c = 0; c < 40; c++) begin
                s = (xfers == 5);
                if (valid) begin
                    chk("busy.byte", {24'd0, data}, {24'd0, 8'(xfers)});
                    xfers++;
                end
                cyc(s, 1'b1);
                if (done) dones++;
            end
            chk("busy.xfers", xfers, 32'd16);
            chk("busy.dones", dones, 32'd1);
            chk_idle("busy.after");
        end

        // Reset mid-dump after byte 7 accepted
        cyc(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1);
        chk("mid.byte8", {23'd0, valid, data}, {23'd0, 1'b1, 8'h08});
        do_reset();
        chk_idle("mid.reset");
        cyc(1'b0, 1'b1);
        chk_idle("mid.nodone");
        cyc(1'b1, 1'b1);
        chk("mid.restart", {23'd0, valid, data}, {23'd0, 1'b1, 8'h00});
        cyc(1'b0, 1'b1);
        chk("mid.restart1", {23'd0, valid, data}, {23'd0, 1'b1, 8'h01});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
